// File: rtl/bypass_scoreboard_pkg.sv
// Shared core definitions: writeback-source encodings and register address type.
package bypass_scoreboard_pkg;

    localparam int DEF_ADDR_W = 6;

    // Register address (integer + floating-point file).
    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

    // Writeback source of a pipeline stage; a stage whose result comes from
    // memory is still pending while it sits in EX, which drives fwd_pend.
    typedef enum logic [1:0] {
        SEL_ALU  = 2'd0,
        SEL_MEM  = 2'd1,
        SEL_CSR  = 2'd2,
        SEL_LONG = 2'd3
    } wb_sel_e;

    // True when a stage with this writeback source has no data yet.
    function automatic logic sel_is_pending(input wb_sel_e sel);
        return (sel == SEL_MEM) || (sel == SEL_LONG);
    endfunction

endpackage

// File: rtl/bypass_mux.sv
// Per-source-port operand selection: youngest matching stage, then the
// long-latency writeback, then the register file value.
module bypass_mux
    import bypass_scoreboard_pkg::*;
#(
    parameter int N_FWD  = 2,
    parameter int ADDR_W = 6,
    parameter int XLEN   = 32
) (
    input  logic                          i_rena,
    input  logic [ADDR_W-1:0]             i_addr,
    input  logic [XLEN-1:0]               i_rf_data,
    input  logic [N_FWD-1:0]              i_fwd_wena,
    input  logic [N_FWD-1:0][ADDR_W-1:0]  i_fwd_addr,
    input  logic [N_FWD-1:0][XLEN-1:0]    i_fwd_data,
    input  logic [N_FWD-1:0]              i_fwd_pend,
    input  logic                          i_lw_wena,
    input  logic [ADDR_W-1:0]             i_lw_addr,
    input  logic [XLEN-1:0]               i_lw_data,
    output logic [XLEN-1:0]               o_data,
    output logic                          o_active,
    output logic                          o_fwd_hit,
    output logic                          o_lw_hit,
    output logic                          o_load_use
);

    logic              w_active;
    logic              w_fwd_hit;
    logic              w_lw_hit;
    logic              w_load_use;
    logic [XLEN-1:0]   w_fwd_val;

    // Priority scan from the youngest stage; the first hit decides data and load-use.
    always_comb begin
        w_active   = i_rena && (i_addr != '0);
        w_fwd_hit  = 1'b0;
        w_load_use = 1'b0;
        w_fwd_val  = '0;
        for (int j = 0; j < N_FWD; j++) begin
            if (!w_fwd_hit && w_active && i_fwd_wena[j] && (i_fwd_addr[j] == i_addr)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_val  = i_fwd_data[j];
                w_load_use = i_fwd_pend[j];
            end
        end
        w_lw_hit = w_active && i_lw_wena && (i_lw_addr == i_addr);
    end

    // Final operand mux.
    always_comb begin
        if (w_fwd_hit) begin
            o_data = w_fwd_val;
        end else if (w_lw_hit) begin
            o_data = i_lw_data;
        end else begin
            o_data = i_rf_data;
        end
    end

    assign o_active   = w_active;
    assign o_fwd_hit  = w_fwd_hit;
    assign o_lw_hit   = w_lw_hit;
    assign o_load_use = w_load_use;

endmodule

// File: rtl/bypass_scoreboard.sv
// ID-stage operand bypass with a busy scoreboard for long-latency results
// and a single combined stall for load-use, RAW, WAW and full hazards.
module bypass_scoreboard
    import bypass_scoreboard_pkg::*;
#(
    parameter int N_RS     = 3,
    parameter int N_FWD    = 2,
    parameter int ADDR_W   = 6,
    parameter int XLEN     = 32,
    parameter int MAX_PEND = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [N_RS-1:0]               rs_rena_ID,
    input  logic [N_RS-1:0][ADDR_W-1:0]   rs_addr_ID,
    input  logic [N_RS-1:0][XLEN-1:0]     rs_data_ID,
    input  logic                          rd_wena_ID,
    input  logic [ADDR_W-1:0]             rd_addr_ID,
    input  logic                          long_lat_ID,
    input  logic                          issue_ID,
    input  logic [N_FWD-1:0]              fwd_wena,
    input  logic [N_FWD-1:0][ADDR_W-1:0]  fwd_addr,
    input  logic [N_FWD-1:0][XLEN-1:0]    fwd_data,
    input  logic [N_FWD-1:0]              fwd_pend,
    input  logic                          lw_wena,
    input  logic [ADDR_W-1:0]             lw_addr,
    input  logic [XLEN-1:0]               lw_data,
    input  logic                          lw_cancel,
    output logic [N_RS-1:0][XLEN-1:0]     rs_data,
    output logic                          stall_ID,
    output logic [$clog2(MAX_PEND+1)-1:0] pend_cnt,
    output logic                          sb_full
);

    localparam int N_REGS = 1 << ADDR_W;
    localparam int CNT_W  = $clog2(MAX_PEND + 1);

    logic [N_REGS-1:0] r_busy;
    logic [N_REGS-1:0] w_busy_next;
    logic [CNT_W-1:0]  r_pend_cnt;

    logic [N_RS-1:0]   w_active;
    logic [N_RS-1:0]   w_fwd_hit;
    logic [N_RS-1:0]   w_lw_hit;
    logic [N_RS-1:0]   w_load_use;
    logic [N_RS-1:0]   w_raw;

    logic              w_lw_clr;
    logic              w_lw_clr_rd;
    logic              w_waw;
    logic              w_full_haz;
    logic              w_set;
    logic              w_set_new;

    genvar gi;
    generate
        for (gi = 0; gi < N_RS; gi++) begin : g_port
            bypass_mux #(
                .N_FWD  (N_FWD),
                .ADDR_W (ADDR_W),
                .XLEN   (XLEN)
            ) u_mux (
                .i_rena     (rs_rena_ID[gi]),
                .i_addr     (rs_addr_ID[gi]),
                .i_rf_data  (rs_data_ID[gi]),
                .i_fwd_wena (fwd_wena),
                .i_fwd_addr (fwd_addr),
                .i_fwd_data (fwd_data),
                .i_fwd_pend (fwd_pend),
                .i_lw_wena  (lw_wena),
                .i_lw_addr  (lw_addr),
                .i_lw_data  (lw_data),
                .o_data     (rs_data[gi]),
                .o_active   (w_active[gi]),
                .o_fwd_hit  (w_fwd_hit[gi]),
                .o_lw_hit   (w_lw_hit[gi]),
                .o_load_use (w_load_use[gi])
            );

            // Busy source with nothing in flight that can supply it this cycle.
            assign w_raw[gi] = w_active[gi] && r_busy[rs_addr_ID[gi]]
                               && !w_fwd_hit[gi] && !w_lw_hit[gi];
        end
    endgenerate

    // Destination hazards and scoreboard set/clear decode.
    always_comb begin
        w_lw_clr    = lw_wena && r_busy[lw_addr];
        w_lw_clr_rd = w_lw_clr && (lw_addr == rd_addr_ID);
        w_waw       = rd_wena_ID && (rd_addr_ID != '0) && r_busy[rd_addr_ID] && !w_lw_clr_rd;
        w_full_haz  = rd_wena_ID && long_lat_ID && sb_full && !w_lw_clr;
        w_set       = issue_ID && rd_wena_ID && long_lat_ID && (rd_addr_ID != '0);
        // A set only adds an entry when its target is not still busy after this cycle's clear.
        w_set_new   = w_set && !(r_busy[rd_addr_ID] && !w_lw_clr_rd);
        stall_ID    = (|w_load_use) || (|w_raw) || w_waw || w_full_haz;
    end

    // Next busy vector: clear first so a same-address set wins.
    always_comb begin
        w_busy_next = r_busy;
        if (w_lw_clr) begin
            w_busy_next[lw_addr] = 1'b0;
        end
        if (w_set) begin
            w_busy_next[rd_addr_ID] = 1'b1;
        end
    end

    // Scoreboard and outstanding-write counter; cancel drops everything.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy     <= '0;
            r_pend_cnt <= '0;
        end else if (lw_cancel) begin
            r_busy     <= '0;
            r_pend_cnt <= '0;
        end else begin
            r_busy <= w_busy_next;
            if (w_set_new && !w_lw_clr) begin
                r_pend_cnt <= r_pend_cnt + CNT_W'(1);
            end else if (!w_set_new && w_lw_clr) begin
                r_pend_cnt <= r_pend_cnt - CNT_W'(1);
            end
        end
    end

    assign pend_cnt = r_pend_cnt;
    assign sb_full  = (r_pend_cnt == CNT_W'(MAX_PEND));

endmodule

// File: tb/tb_bypass_scoreboard.sv
// Scoreboard-style bench: the driver predicts each cycle's outputs from a
// behavioural model and queues them; a monitor compares on the falling edge.
module tb_bypass_scoreboard;

    localparam int N_RS     = 3;
    localparam int N_FWD    = 2;
    localparam int ADDR_W   = 6;
    localparam int XLEN     = 32;
    localparam int MAX_PEND = 4;
    localparam int CNT_W    = $clog2(MAX_PEND + 1);
    localparam int N_REGS   = 1 << ADDR_W;

    logic                          clk;
    logic                          reset_n;
    logic [N_RS-1:0]               rs_rena_ID;
    logic [N_RS-1:0][ADDR_W-1:0]   rs_addr_ID;
    logic [N_RS-1:0][XLEN-1:0]     rs_data_ID;
    logic                          rd_wena_ID;
    logic [ADDR_W-1:0]             rd_addr_ID;
    logic                          long_lat_ID;
    logic                          issue_ID;
    logic [N_FWD-1:0]              fwd_wena;
    logic [N_FWD-1:0][ADDR_W-1:0]  fwd_addr;
    logic [N_FWD-1:0][XLEN-1:0]    fwd_data;
    logic [N_FWD-1:0]              fwd_pend;
    logic                          lw_wena;
    logic [ADDR_W-1:0]             lw_addr;
    logic [XLEN-1:0]               lw_data;
    logic                          lw_cancel;
    logic [N_RS-1:0][XLEN-1:0]     rs_data;
    logic                          stall_ID;
    logic [CNT_W-1:0]              pend_cnt;
    logic                          sb_full;

    bypass_scoreboard #(
        .N_RS     (N_RS),
        .N_FWD    (N_FWD),
        .ADDR_W   (ADDR_W),
        .XLEN     (XLEN),
        .MAX_PEND (MAX_PEND)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rs_rena_ID  (rs_rena_ID),
        .rs_addr_ID  (rs_addr_ID),
        .rs_data_ID  (rs_data_ID),
        .rd_wena_ID  (rd_wena_ID),
        .rd_addr_ID  (rd_addr_ID),
        .long_lat_ID (long_lat_ID),
        .issue_ID    (issue_ID),
        .fwd_wena    (fwd_wena),
        .fwd_addr    (fwd_addr),
        .fwd_data    (fwd_data),
        .fwd_pend    (fwd_pend),
        .lw_wena     (lw_wena),
        .lw_addr     (lw_addr),
        .lw_data     (lw_data),
        .lw_cancel   (lw_cancel),
        .rs_data     (rs_data),
        .stall_ID    (stall_ID),
        .pend_cnt    (pend_cnt),
        .sb_full     (sb_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int                       id;
        logic [N_RS-1:0][XLEN-1:0] data;
        bit                       stall;
        int                       cnt;
        bit                       full;
    } exp_t;

    exp_t q_exp[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   txn_id   = 0;
    bit   id_valid;
    bit   m_busy [N_REGS];

    // ---------------- reference model ----------------
    function automatic int m_count();
        int c = 0;
        for (int r = 0; r < N_REGS; r++) if (m_busy[r]) c++;
        return c;
    endfunction

    function automatic exp_t model_eval();
        exp_t e;
        int   cnt;
        bit   lw_clears;
        cnt       = m_count();
        lw_clears = lw_wena && m_busy[lw_addr];
        e.id      = txn_id;
        e.stall   = 1'b0;
        e.cnt     = cnt;
        e.full    = (cnt == MAX_PEND);
        for (int i = 0; i < N_RS; i++) begin
            int  a;
            int  win;
            bit  act;
            bit  lwm;
            a   = int'(rs_addr_ID[i]);
            act = rs_rena_ID[i] && (a != 0);
            lwm = act && lw_wena && (int'(lw_addr) == a);
            win = -1;
            if (act) begin
                for (int j = N_FWD - 1; j >= 0; j--)
                    if (fwd_wena[j] && int'(fwd_addr[j]) == a) win = j;
            end
            if (win >= 0) begin
                e.data[i] = fwd_data[win];
                if (fwd_pend[win]) e.stall = 1'b1;
            end else if (lwm) begin
                e.data[i] = lw_data;
            end else begin
                e.data[i] = rs_data_ID[i];
            end
            if (act && m_busy[a] && win < 0 && !lwm) e.stall = 1'b1;
        end
        if (rd_wena_ID && rd_addr_ID != 0 && m_busy[rd_addr_ID]
            && !(lw_clears && lw_addr == rd_addr_ID)) e.stall = 1'b1;
        if (rd_wena_ID && long_lat_ID && e.full && !lw_clears) e.stall = 1'b1;
        return e;
    endfunction

    function automatic void model_update();
        if (lw_cancel) begin
            for (int r = 0; r < N_REGS; r++) m_busy[r] = 1'b0;
        end else begin
            if (lw_wena) m_busy[lw_addr] = 1'b0;
            if (issue_ID && rd_wena_ID && long_lat_ID && rd_addr_ID != 0) m_busy[rd_addr_ID] = 1'b1;
        end
    endfunction

    // ---------------- driver helpers ----------------
    task automatic idle();
        rs_rena_ID  = '0;
        rs_addr_ID  = '0;
        rs_data_ID  = '0;
        rd_wena_ID  = 1'b0;
        rd_addr_ID  = '0;
        long_lat_ID = 1'b0;
        id_valid    = 1'b0;
        issue_ID    = 1'b0;
        fwd_wena    = '0;
        fwd_addr    = '0;
        fwd_data    = '0;
        fwd_pend    = '0;
        lw_wena     = 1'b0;
        lw_addr     = '0;
        lw_data     = '0;
        lw_cancel   = 1'b0;
    endtask

    // Called at posedge+1 with inputs set; predicts, queues, advances the model.
    task automatic step();
        exp_t e;
        e        = model_eval();
        issue_ID = id_valid && !e.stall;
        q_exp.push_back(e);
        model_update();
        txn_id++;
        @(posedge clk);
        #1;
    endtask

    task automatic long_op(input int rd);
        idle();
        rd_wena_ID  = 1'b1;
        rd_addr_ID  = ADDR_W'(rd);
        long_lat_ID = 1'b1;
        id_valid    = 1'b1;
    endtask

    task automatic check(input string name, input int id, input logic [XLEN-1:0] got,
                         input logic [XLEN-1:0] req);
        n_checks++;
        if (got !== req) begin
            n_errors++;
            $display("FAIL %s txn=%0d got=%h required=%h", name, id, got, req);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                for (int i = 0; i < N_RS; i++) check("rs_data", e.id, rs_data[i], e.data[i]);
                check("stall_ID", e.id, XLEN'(stall_ID), XLEN'(e.stall));
                check("pend_cnt", e.id, XLEN'(pend_cnt), XLEN'(e.cnt));
                check("sb_full",  e.id, XLEN'(sb_full),  XLEN'(e.full));
                $display("txn %0d: stall=%0b pend_cnt=%0d sb_full=%0b rs_data=%h/%h/%h",
                         e.id, stall_ID, pend_cnt, sb_full, rs_data[0], rs_data[1], rs_data[2]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset_n = 1'b0;
        idle();
        for (int r = 0; r < N_REGS; r++) m_busy[r] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state with idle inputs.
        step();

        // Stage priority: both stages hit x5, youngest wins.
        idle();
        rs_rena_ID[0] = 1'b1; rs_addr_ID[0] = 6'd5; rs_data_ID[0] = 32'h1111;
        fwd_wena = 2'b11; fwd_addr[0] = 6'd5; fwd_addr[1] = 6'd5;
        fwd_data[0] = 32'hAAAA; fwd_data[1] = 32'hBBBB;
        step();

        // Load-use on x7, then the load moves to stage 1.
        idle();
        rs_rena_ID[1] = 1'b1; rs_addr_ID[1] = 6'd7; rs_data_ID[1] = 32'h7777;
        fwd_wena[0] = 1'b1; fwd_addr[0] = 6'd7; fwd_pend[0] = 1'b1; fwd_data[0] = 32'hDEAD;
        step();
        idle();
        rs_rena_ID[1] = 1'b1; rs_addr_ID[1] = 6'd7; rs_data_ID[1] = 32'h7777;
        fwd_wena[1] = 1'b1; fwd_addr[1] = 6'd7; fwd_data[1] = 32'h0C0C;
        step();

        // Long RAW on x9 released by same-cycle writeback.
        long_op(9);
        step();
        idle();
        rs_rena_ID[0] = 1'b1; rs_addr_ID[0] = 6'd9;
        step();
        lw_wena = 1'b1; lw_addr = 6'd9; lw_data = 32'h1234;
        step();
        idle();
        step();

        // Fill the scoreboard, then a fifth long op stalls until a clear frees a slot.
        for (int r = 1; r <= 4; r++) begin
            long_op(r);
            step();
        end
        long_op(5);
        step();
        lw_wena = 1'b1; lw_addr = 6'd2; lw_data = 32'h2222;
        step();

        // WAW on busy x3, then set/clear collision on x3.
        idle();
        rd_wena_ID = 1'b1; rd_addr_ID = 6'd3; id_valid = 1'b1;
        step();
        long_op(3);
        lw_wena = 1'b1; lw_addr = 6'd3; lw_data = 32'h3333;
        step();
        idle();
        rs_rena_ID[2] = 1'b1; rs_addr_ID[2] = 6'd3;
        step();

        // Cancel drops everything.
        idle();
        lw_cancel = 1'b1;
        step();
        idle();
        rs_rena_ID[2] = 1'b1; rs_addr_ID[2] = 6'd3;
        step();

        // Async reset pulse between edges clears pending entries at once.
        for (int r = 1; r <= 3; r++) begin
            long_op(r);
            step();
        end
        idle();
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_rst_pend_cnt", txn_id, XLEN'(pend_cnt), '0);
        check("async_rst_sb_full", txn_id, XLEN'(sb_full), '0);
        for (int r = 0; r < N_REGS; r++) m_busy[r] = 1'b0;
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        rs_rena_ID[0] = 1'b1; rs_addr_ID[0] = 6'd1;
        step();

        // Randomized traffic over a small address window to provoke hits.
        for (int n = 0; n < 600; n++) begin
            idle();
            for (int i = 0; i < N_RS; i++) begin
                rs_rena_ID[i] = 1'($urandom_range(0, 1));
                rs_addr_ID[i] = ADDR_W'($urandom_range(0, 7));
                rs_data_ID[i] = $urandom;
            end
            for (int j = 0; j < N_FWD; j++) begin
                fwd_wena[j] = ($urandom_range(0, 2) != 0);
                fwd_addr[j] = ADDR_W'($urandom_range(0, 7));
                fwd_data[j] = $urandom;
                fwd_pend[j] = ($urandom_range(0, 5) == 0);
            end
            rd_wena_ID  = 1'($urandom_range(0, 1));
            rd_addr_ID  = ADDR_W'($urandom_range(0, 7));
            long_lat_ID = ($urandom_range(0, 2) == 0);
            id_valid    = ($urandom_range(0, 3) != 0);
            lw_wena     = ($urandom_range(0, 2) == 0);
            lw_addr     = ADDR_W'($urandom_range(0, 7));
            lw_data     = $urandom;
            lw_cancel   = ($urandom_range(0, 60) == 0);
            step();
        end
        idle();

        // Drain the monitor queue within a bounded number of cycles.
        for (int k = 0; k < 10 && q_exp.size() > 0; k++) @(negedge clk);
        #1;
        n_checks++;
        if (q_exp.size() != 0) begin
            n_errors++;
            $display("FAIL drain queue_left=%0d required=0", q_exp.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
